uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit serializer between NREQ byte requesters using round-robin arbitration.
- Latches the winning byte and generates its own baud tick. Shifts out one 11-bit frame: start 0, data MSB first, even parity (XOR of data), stop 1. This is the same frame format the team's transmitter uses.
- Sits between the APB register layer (one requester per source) and the tx pin.

Parameters:
- NREQ, 2, number of requesters (2..8).
- CLKS_PER_BIT, 8, clk cycles per serial bit (>=2).
- IDW, $clog2(NREQ) (min 1), width of grant_id.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  level request per requester; hold until ack.
- data_in  input  NREQ*8  byte per requester; requester i uses bits [8i+7:8i]; stable while req[i]=1.
- ack  output  NREQ  one-hot, one-cycle pulse: byte accepted.
- grant_id  output  IDW  index of requester owning the current frame.
- busy  output  1  high while a frame is being shifted.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (rst=0, async): tx=1, busy=0, ack=0, grant_id=0, state=IDLE, baud count=0, bit index=0. The round-robin pointer resets so requester 0 has highest priority.
- States: IDLE -> SHIFT -> IDLE.
- IDLE:
  - tx=1.
  - On a rising edge with any req bit set, pick the first set bit searching upward from (last_grant+1) mod NREQ, with wrap.
  - On that edge, register: byte, frame, grant_id, and ack[winner]=1. Also set busy=1, tx=0 (start bit), state=SHIFT.
  - ack is high exactly one cycle, coincident with the first start-bit cycle.
- SHIFT:
  - Each frame bit is held exactly CLKS_PER_BIT cycles. The baud counter restarts at acceptance.
  - Bit order: 0, d7..d0, ^d, 1.
  - The frame lasts 11*CLKS_PER_BIT cycles from acceptance.
  - After the stop bit's last cycle: state=IDLE, busy=0, tx stays 1.
  - In SHIFT, req is ignored. Changes to data_in are ignored because the byte is latched.
- Back-to-back: if req is pending when the stop bit ends, the next start bit begins the very next cycle (zero idle gap). Minimum frame period is 11*CLKS_PER_BIT.
- Fairness:
  - The pointer updates to the winner on each grant.
  - With all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0.
  - A single requester may win consecutively if it is the only one requesting.
- Requester dropping req before ack: no grant, no frame, no error.
- Simultaneous requests: exactly one ack per frame; never two ack bits high.
- Reset mid-frame: the frame aborts immediately and tx=1 asynchronously. The pending requester is not acked again until it re-wins after reset.
- grant_id holds the last winner until the next grant.

Optional Feature:
- Macro: UART_TX_ARB_ODD_PARITY_EN.
- Defined: parity bit = ~^data (odd parity).
- Undefined: parity bit = ^data (even parity, default).
- Frame length and timing are unchanged either way.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state typedef (IDLE, SHIFT);
  - FRAME_BITS=11;
  - START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module uart_baud_tick: counter of CLKS_PER_BIT with sync clear and a tick output. Instantiated once and cleared on acceptance.
- Arbitration (rotate, priority-encode, rotate back) stays in the top module.

Test Plan:
- Single frame:
  - Stimulus: NREQ=2, CLKS_PER_BIT=8, req=2'b01, data_in[7:0]=8'hA5.
  - Response: ack=2'b01 for 1 cycle; tx per 8-cycle slot = 0,1,0,1,0,0,1,0,1, parity 0, stop 1; busy high 88 cycles.
- Contention:
  - Stimulus: req=2'b11 held, bytes 8'h01 (req0) and 8'h80 (req1).
  - Response: grants 0,1,0,1. Each frame starts the cycle after the previous stop bit ends, and grant_id toggles.
- Parity boundaries:
  - Stimulus: bytes 8'h00 and 8'hFF.
  - Response: parity bit 0 for both by default; 1 for both with UART_TX_ARB_ODD_PARITY_EN.
- Mid-frame data change:
  - Stimulus: change data_in during SHIFT.
  - Response: tx still carries the latched byte; no extra ack.
- Reset mid-frame:
  - Stimulus: drop rst at bit 4 with req=2'b10 held.
  - Response: tx=1 and busy=0 with no clock. After release, req1 gets ack and a full frame restarts from the start bit.
- Late request:
  - Stimulus: req0 raised during req1's frame.
  - Response: no ack until req1's stop bit completes, then ack0 the next cycle.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared state type, frame constants and parity helper for uart_tx_arbiter
// UART_TX_ARB_ODD_PARITY_EN selects odd parity instead of the default even parity.
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  function automatic logic parity_bit(input logic [7:0] d);
`ifdef UART_TX_ARB_ODD_PARITY_EN
    return ~^d;
`else
    return ^d;
`endif
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter; tick marks the last clk of each serial bit
// clr restarts the period so the first bit after acceptance is a full CLKS_PER_BIT long.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr || tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 11-bit UART tx serializer
// Parity polarity follows UART_TX_ARB_ODD_PARITY_EN (see uart_tx_arb_pkg).
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int CLKS_PER_BIT = 8,
  parameter int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data_in,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              tx
);

  localparam int SHW = FRAME_BITS - 1;
  localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
  localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);

  state_e           state_q, state_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [3:0]       bit_q, bit_d;
  logic [SHW-1:0]   shreg_q, shreg_d;

  logic             accept;
  logic             baud_en;
  logic             baud_tick;

  logic [IDW-1:0]   start_id;
  logic [IDW-1:0]   enc_id;
  logic [IDW-1:0]   win_id;
  logic [IDW:0]     win_sum;
  logic [NREQ-1:0]  req_rot;
  logic [7:0]       win_byte;

  assign baud_en = (state_q == SHIFT);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst),
    .clr  (accept),
    .en   (baud_en),
    .tick (baud_tick)
  );

  // Rotate so the requester after the last winner sits at bit 0, take the
  // lowest set bit, then rotate the index back into requester numbering.
  always_comb begin
    start_id = (ptr_q == LAST_ID) ? '0 : ptr_q + 1'b1;
    req_rot  = NREQ'({req, req} >> start_id);
    enc_id   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        enc_id = IDW'(k);
      end
    end
    win_sum = {1'b0, enc_id} + {1'b0, start_id};
    if (win_sum >= NREQ_W) begin
      win_sum = win_sum - NREQ_W;
    end
    win_id   = win_sum[IDW-1:0];
    win_byte = 8'(data_in >> {win_id, 3'b000});
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ack_d   = '0;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        accept = |req;
      end
      SHIFT: begin
        if (baud_tick) begin
          if (bit_q == LAST_BIT) begin
            // A pending request starts its frame with no idle gap.
            if (|req) begin
              accept = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = STOP_BIT;
              bit_d   = '0;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shreg_q[SHW-1];
            shreg_d = {shreg_q[SHW-2:0], STOP_BIT};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      busy_d  = 1'b1;
      tx_d    = START_BIT;
      ack_d   = NREQ'(1) << win_id;
      grant_d = win_id;
      ptr_d   = win_id;
      bit_d   = '0;
      shreg_d = {win_byte, parity_bit(win_byte), STOP_BIT};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      ptr_q   <= LAST_ID;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign grant_id = grant_q;

endmodule
